// File: rtl/ram_master.sv
// Command-stream initiator for an edge-strobed 8-bit RAM port: one access in flight, registered strobes.
// Optional read timeout is enabled by defining RAM_MASTER_TIMEOUT_EN.
module ram_master #(
  parameter int unsigned STROBE_CYCLES  = 2,
`ifdef RAM_MASTER_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 16,
`endif
  parameter int unsigned GAP_CYCLES     = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_cmd_write,
  input  logic [7:0] i_cmd_addr,
  input  logic [7:0] i_cmd_wdata,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_err,
  output logic       o_busy,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic [7:0] o_mem_read_addr,
  output logic [7:0] o_mem_write_addr,
  output logic [7:0] o_mem_wdata,
  input  logic [7:0] i_mem_data,
  input  logic       i_mem_valid,
  output logic [1:0] o_dbg_state
);

  // Handshake: a command transfers on a clock edge where i_cmd_valid && o_cmd_ready;
  // o_cmd_ready is high only in IDLE and never depends on i_cmd_valid.
  typedef enum logic [1:0] {ST_IDLE, ST_STROBE, ST_GAP, ST_WAIT} state_e;

  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       is_write_q, is_write_d;
  logic       got_q, got_d;
  logic [7:0] cap_q, cap_d;
  logic       rd_q, rd_d, wr_q, wr_d;
  logic [7:0] raddr_q, raddr_d, waddr_q, waddr_d, wdata_q, wdata_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
`ifdef RAM_MASTER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tcnt_q, tcnt_d;
  logic       rsp_err_q, rsp_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_write_d  = is_write_q;
    got_d       = got_q;
    cap_d       = cap_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    raddr_d     = raddr_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
`ifdef RAM_MASTER_TIMEOUT_EN
    rsp_err_d   = 1'b0;
    tcnt_d      = tcnt_q;
    if (state_q != ST_IDLE && tcnt_q < TIMEOUT_LAST) tcnt_d = tcnt_q + 8'd1;
`endif
    // Only the first i_mem_valid pulse of a read is kept; WAIT consumes its pulse directly.
    if ((state_q == ST_STROBE || state_q == ST_GAP) && !is_write_q && i_mem_valid && !got_q) begin
      got_d = 1'b1;
      cap_d = i_mem_data;
    end
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          state_d    = ST_STROBE;
          cnt_d      = 8'd0;
          got_d      = 1'b0;
          is_write_d = i_cmd_write;
`ifdef RAM_MASTER_TIMEOUT_EN
          tcnt_d     = 8'd0;
`endif
          if (i_cmd_write) begin
            wr_d    = 1'b1;
            waddr_d = i_cmd_addr;
            wdata_d = i_cmd_wdata;
          end else begin
            rd_d    = 1'b1;
            raddr_d = i_cmd_addr;
          end
        end
      end
      ST_STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          cnt_d   = 8'd0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q != GAP_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end else if (is_write_q) begin
          state_d = ST_IDLE;
        end else if (got_q || i_mem_valid) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = got_q ? cap_q : i_mem_data;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_mem_valid) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = i_mem_data;
        end
`ifdef RAM_MASTER_TIMEOUT_EN
        else if (tcnt_q >= TIMEOUT_LAST) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = 8'hFF;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      is_write_q  <= 1'b0;
      got_q       <= 1'b0;
      cap_q       <= 8'd0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      raddr_q     <= 8'd0;
      waddr_q     <= 8'd0;
      wdata_q     <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
`ifdef RAM_MASTER_TIMEOUT_EN
      tcnt_q      <= 8'd0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_write_q  <= is_write_d;
      got_q       <= got_d;
      cap_q       <= cap_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef RAM_MASTER_TIMEOUT_EN
      tcnt_q      <= tcnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign o_cmd_ready      = (state_q == ST_IDLE);
  assign o_busy           = (state_q != ST_IDLE);
  assign o_rsp_valid      = rsp_valid_q;
  assign o_rsp_data       = rsp_data_q;
  assign o_mem_read       = rd_q;
  assign o_mem_write      = wr_q;
  assign o_mem_read_addr  = raddr_q;
  assign o_mem_write_addr = waddr_q;
  assign o_mem_wdata      = wdata_q;
  assign o_dbg_state      = state_q;
`ifdef RAM_MASTER_TIMEOUT_EN
  assign o_rsp_err        = rsp_err_q;
`else
  assign o_rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_ram_master.sv
// Self-checking bench for ram_master: RAM model, reference memory + expected response queue,
// table-driven back-to-back vectors, hand-written corner sequences and randomized traffic.
module tb_ram_master;
  localparam int STROBE  = 2;
  localparam int GAP     = 1;
  localparam int TIMEOUT = 16;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_cmd_valid = 1'b0;
  logic       i_cmd_write = 1'b0;
  logic [7:0] i_cmd_addr = 8'd0;
  logic [7:0] i_cmd_wdata = 8'd0;
  logic [7:0] i_mem_data = 8'd0;
  logic       i_mem_valid = 1'b0;
  logic       o_cmd_ready, o_rsp_valid, o_rsp_err, o_busy, o_mem_read, o_mem_write;
  logic [7:0] o_rsp_data, o_mem_read_addr, o_mem_write_addr, o_mem_wdata;
  logic [1:0] o_dbg_state;

  ram_master dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err), .o_busy(o_busy),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_read_addr(o_mem_read_addr), .o_mem_write_addr(o_mem_write_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_data(i_mem_data), .i_mem_valid(i_mem_valid),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;
  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- RAM model ----------------
  // ram_mode: 0 = answer after ram_lat cycles, 1 = never answer, 2 = double pulse 0x11 then 0x22
  logic [7:0] ram     [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  int         ram_mode = 0;
  int         ram_lat = 1;
  int         pend = 0, pend2 = 0;
  logic       rd_prev = 1'b0, wr_prev = 1'b0;
  logic [7:0] rd_addr = 8'd0;

  always begin
    @(posedge i_clk); #1;
    i_mem_valid = 1'b0;
    i_mem_data  = 8'($urandom);
    if (!i_rst_n) begin
      pend = 0; pend2 = 0; rd_prev = 1'b0; wr_prev = 1'b0;
    end else begin
      if (o_mem_write && !wr_prev) ram[o_mem_write_addr] = o_mem_wdata;
      if (o_mem_read && !rd_prev) begin
        rd_addr = o_mem_read_addr;
        if (ram_mode == 0) pend = ram_lat;
        else if (ram_mode == 2) begin pend = 1; pend2 = 3; end
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          i_mem_valid = 1'b1;
          i_mem_data  = (ram_mode == 2) ? 8'h11 : ram[rd_addr];
        end
      end
      if (pend2 > 0) begin
        pend2--;
        if (pend2 == 0) begin i_mem_valid = 1'b1; i_mem_data = 8'h22; end
      end
      // stray pulses while idle must be ignored by the initiator
      if (ram_mode == 0 && !o_busy && pend == 0 && $urandom_range(0, 7) == 0) i_mem_valid = 1'b1;
      rd_prev = o_mem_read;
      wr_prev = o_mem_write;
    end
  end

  // ---------------- scoreboard / protocol monitor ----------------
  logic [8:0] exp_q[$];
  int         rsp_count = 0;
  int unsigned last_rsp_cyc = 0;
  int         run = 0, low_run = 0;
  bit         seen_access = 0;
  logic [7:0] held_addr, held_wdata;

  always begin
    logic [8:0] e;
    logic [7:0] cur_addr;
    @(posedge i_clk); #1;
    if (!i_rst_n) begin
      run = 0; low_run = 0; seen_access = 0;
    end else begin
      if (o_rsp_valid) begin
        rsp_count++;
        last_rsp_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("rsp_data", 32'(o_rsp_data), 32'(e[7:0]));
          check("rsp_err", 32'(o_rsp_err), 32'(e[8]));
        end
      end
      if (o_mem_read && o_mem_write) check("strobe_exclusive", 1, 0);
      cur_addr = o_mem_read ? o_mem_read_addr : o_mem_write_addr;
      if (o_mem_read || o_mem_write) begin
        if (run == 0) begin
          if (seen_access) check("gap_low_cycles", 32'(low_run >= GAP), 1);
          held_addr  = cur_addr;
          held_wdata = o_mem_wdata;
        end else begin
          check("addr_stable", 32'(cur_addr), 32'(held_addr));
          if (o_mem_write) check("wdata_stable", 32'(o_mem_wdata), 32'(held_wdata));
        end
        run++;
        low_run = 0;
        seen_access = 1;
      end else begin
        if (run > 0) check("strobe_high_cycles", 32'(run), 32'(STROBE));
        run = 0;
        low_run++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int unsigned accept_cyc = 0;

  // Leaves i_cmd_valid high so successive calls form a back-to-back stream.
  task automatic send_cmd(input bit w, input logic [7:0] a, input logic [7:0] d,
                          input bit has_exp, input logic [8:0] e);
    int guard = 0;
    @(negedge i_clk);
    i_cmd_valid = 1'b1; i_cmd_write = w; i_cmd_addr = a; i_cmd_wdata = d;
    while (!o_cmd_ready && guard < 200) begin @(negedge i_clk); guard++; end
    if (!o_cmd_ready) begin
      check("accept_timeout", 0, 1);
      i_cmd_valid = 1'b0;
      return;
    end
    @(posedge i_clk);
    if (w) ref_mem[a] = d;
    else if (has_exp) exp_q.push_back(e);
    #1 accept_cyc = cyc;
  endtask

  task automatic cmd_idle();
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (!o_busy && exp_q.size() == 0) break;
    end
    check({name, "_busy"}, 32'(o_busy), 0);
    check({name, "_pending"}, 32'(exp_q.size()), 0);
  endtask

  typedef struct {
    bit         write;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int   rc, bad, bad_mem;
    int unsigned prev_acc;
    tbl[0] = '{1'b0, 8'h10, 8'h00, 8'h3C};
    tbl[1] = '{1'b1, 8'h01, 8'hA5, 8'h00};
    tbl[2] = '{1'b0, 8'h01, 8'h00, 8'hA5};
    tbl[3] = '{1'b0, 8'h02, 8'h00, 8'h00};
    tbl[4] = '{1'b1, 8'h02, 8'h5A, 8'h00};
    tbl[5] = '{1'b0, 8'h02, 8'h00, 8'h5A};

    // reset state
    #2;
    check("rst_ready", 32'(o_cmd_ready), 1);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_strobes", 32'({o_mem_read, o_mem_write}), 0);
    check("rst_rsp", 32'({o_rsp_valid, o_rsp_err, o_rsp_data}), 0);
    check("rst_mem_bus", 32'({o_mem_read_addr, o_mem_write_addr, o_mem_wdata}), 0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;

    // 1: reset in the middle of a read strobe
    ram_mode = 1;
    send_cmd(1'b0, 8'h05, 8'h00, 1'b0, 9'h0);
    cmd_idle();
    @(posedge i_clk); #1;
    check("t1_read_high", 32'(o_mem_read), 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("t1_read_dropped", 32'(o_mem_read), 0);
    check("t1_ready", 32'(o_cmd_ready), 1);
    check("t1_busy", 32'(o_busy), 0);
    rc = rsp_count;
    repeat (2) begin @(posedge i_clk); #1; check("t1_no_rsp_in_reset", 32'(o_rsp_valid), 0); end
    @(negedge i_clk) i_rst_n = 1'b1;
    repeat (4) @(posedge i_clk);
    #1 check("t1_no_rsp_after", 32'(rsp_count), 32'(rc));

    // 2: single write timing
    ram_mode = 0; ram_lat = 1;
    rc = rsp_count;
    send_cmd(1'b1, 8'h10, 8'h3C, 1'b0, 9'h0);
    check("t2_write_n", 32'(o_mem_write), 1);
    check("t2_read_n", 32'(o_mem_read), 0);
    check("t2_ready_n", 32'(o_cmd_ready), 0);
    check("t2_addr", 32'(o_mem_write_addr), 32'h10);
    check("t2_wdata", 32'(o_mem_wdata), 32'h3C);
    cmd_idle();
    @(posedge i_clk); #1 check("t2_write_n1", 32'(o_mem_write), 1);
    @(posedge i_clk); #1;
    check("t2_write_n2", 32'(o_mem_write), 0);
    check("t2_addr_held", 32'({o_mem_write_addr, o_mem_wdata}), 32'h103C);
    check("t2_ready_n2", 32'(o_cmd_ready), 0);
    @(posedge i_clk); #1 check("t2_ready_n3", 32'(o_cmd_ready), 1);
    check("t2_ram", 32'(ram[8'h10]), 32'h3C);
    check("t2_no_rsp", 32'(rsp_count), 32'(rc));

    // 3/4: table-driven back-to-back stream with i_cmd_valid held high
    ram_lat = 2;
    prev_acc = 0;
    for (int i = 0; i < 6; i++) begin
      send_cmd(tbl[i].write, tbl[i].addr, tbl[i].wdata, 1'b1, {1'b0, tbl[i].exp});
      if (i > 0) check("b2b_spacing", 32'(accept_cyc - prev_acc), 32'(1 + STROBE + GAP));
      prev_acc = accept_cyc;
    end
    cmd_idle();
    wait_idle("tbl");

    // 5: double i_mem_valid pulse in one read
    ram_mode = 2;
    rc = rsp_count;
    send_cmd(1'b0, 8'h33, 8'h00, 1'b1, {1'b0, 8'h11});
    cmd_idle();
    wait_idle("t5");
    repeat (3) @(posedge i_clk);
    #1 check("t5_single_rsp", 32'(rsp_count - rc), 1);

    // randomized traffic against the reference memory
    ram_mode = 0;
    for (int i = 0; i < 60; i++) begin
      bit         w;
      logic [7:0] a, d;
      w = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom);
      ram_lat = $urandom_range(1, 8);
      send_cmd(w, a, d, !w, {1'b0, ref_mem[a]});
      if ($urandom_range(0, 2) == 0) begin
        cmd_idle();
        repeat ($urandom_range(0, 3)) @(negedge i_clk);
      end
    end
    cmd_idle();
    wait_idle("rand");
    bad_mem = 0;
    for (int a = 0; a < 256; a++) if (ram[a] !== ref_mem[a]) bad_mem++;
    check("rand_ram_contents", 32'(bad_mem), 0);

    // 6: RAM never answers a read
    ram_mode = 1;
    rc = rsp_count;
`ifdef RAM_MASTER_TIMEOUT_EN
    send_cmd(1'b0, 8'h07, 8'h00, 1'b1, {1'b1, 8'hFF});
    cmd_idle();
    for (int i = 0; i < 40 && rsp_count == rc; i++) @(posedge i_clk);
    #2;
    check("t6_rsp_seen", 32'(rsp_count - rc), 1);
    check("t6_rsp_latency", 32'(last_rsp_cyc - accept_cyc), 32'(TIMEOUT));
    check("t6_ready_after", 32'(o_cmd_ready), 1);
`else
    send_cmd(1'b0, 8'h07, 8'h00, 1'b0, 9'h0);
    cmd_idle();
    bad = 0;
    repeat (100) begin @(posedge i_clk); #1; if (!o_busy) bad++; end
    check("t6_busy_held", 32'(bad), 0);
    check("t6_no_rsp", 32'(rsp_count), 32'(rc));
    @(negedge i_clk) i_rst_n = 1'b0;
    @(negedge i_clk) i_rst_n = 1'b1;
    #1 check("t6_ready_after_reset", 32'(o_cmd_ready), 1);
`endif
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
